// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit 7-segment scan controller: blank/show time slots per digit,
// registered outputs, and a sample strobe every FRAMES_PER_SAMPLE frames.
module display_scan_controller #(
  parameter int unsigned CLK_DIV           = 50000,
  parameter int unsigned BLANK_CYCLES      = 500,
  parameter int unsigned FRAMES_PER_SAMPLE = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] digit_data,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  cur_digit,
  output logic        sample_stb
);

  localparam int unsigned CntMax = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned FrmW   = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(CLK_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast   = FrmW'(FRAMES_PER_SAMPLE - 1);

  typedef enum logic {StBlank, StShow} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      slot_q, slot_d;
  logic            en_q, en_d;
  logic [FrmW-1:0] frame_q, frame_d;
  logic            stb_d;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    slot_d  = slot_q;
    en_d    = en_q;
    frame_d = frame_q;
    stb_d   = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
          en_d    = digit_en[slot_q];
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          slot_d  = slot_q + 2'd1;
          // Last show cycle of slot 3 completes a frame.
          if (slot_q == 2'd3) begin
            if (frame_q == FrmLast) begin
              frame_d = '0;
              stb_d   = 1'b1;
            end else begin
              frame_d = frame_q + FrmW'(1);
            end
          end
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    if (state_d == StShow && en_d) begin
      an_d[slot_d] = 1'b0;
      unique case (slot_d)
        2'd0: seg_d = digit_data[6:0];
        2'd1: seg_d = digit_data[13:7];
        2'd2: seg_d = digit_data[20:14];
        2'd3: seg_d = digit_data[27:21];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBlank;
      cnt_q      <= '0;
      slot_q     <= 2'd0;
      en_q       <= 1'b0;
      frame_q    <= '0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      sample_stb <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      en_q       <= en_d;
      frame_q    <= frame_d;
      an         <= an_d;
      seg        <= seg_d;
      sample_stb <= stb_d;
    end
  end

  assign cur_digit = slot_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with CLK_DIV=4, BLANK_CYCLES=2,
// FRAMES_PER_SAMPLE=2 (frame = 24 cycles, strobe every 48).
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] digit_data;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  cur_digit;
  logic        sample_stb;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [6:0] codes [4];

  display_scan_controller #(
    .CLK_DIV          (4),
    .BLANK_CYCLES     (2),
    .FRAMES_PER_SAMPLE(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_data(digit_data),
    .digit_en  (digit_en),
    .seg       (seg),
    .an        (an),
    .cur_digit (cur_digit),
    .sample_stb(sample_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_cur"}, 32'(cur_digit), 32'd0);
    chk({tag, "_stb"}, 32'(sample_stb), 32'd0);
  endtask

  // Timeline model: 24-cycle frame, slot = 6 cycles (2 blank + 4 show).
  task automatic chk_model(input string tag, input logic [3:0] en);
    int pos, slot, off;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    pos  = cyc % 24;
    slot = pos / 6;
    off  = pos % 6;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    if (off >= 2 && en[slot]) begin
      e_an       = 4'hF;
      e_an[slot] = 1'b0;
      e_seg      = codes[slot];
    end
    chk({tag, "_an"}, 32'(an), 32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "_cur"}, 32'(cur_digit), 32'(slot));
    chk({tag, "_stb"}, 32'(sample_stb), 32'((cyc > 0) && (cyc % 48 == 0)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input string tag, input int last, input logic [3:0] en);
    chk_model(tag, en);
    while (cyc < last) begin
      step();
      chk_model(tag, en);
    end
  endtask

  initial begin
    codes[0] = 7'h40;
    codes[1] = 7'h79;
    codes[2] = 7'h24;
    codes[3] = 7'h30;
    digit_data = {codes[3], codes[2], codes[1], codes[0]};
    digit_en   = 4'hF;

    // Reset held across clock edges
    #12;
    chk_reset_vals("reset_hold");
    @(posedge clk);
    #1;
    chk_reset_vals("reset_hold2");

    // All digits enabled: two strobes at 48 and 96
    release_rst();
    run_to("all_en", 97, 4'hF);

    // Slots 1 and 3 dark
    rst = 1'b1;
    #1;
    chk_reset_vals("reset_b");
    digit_en = 4'b0101;
    release_rst();
    run_to("en_0101", 49, 4'b0101);

    // Mid-slot changes of enable and data
    rst = 1'b1;
    digit_en = 4'hF;
    release_rst();
    run_to("midslot_pre", 3, 4'hF);
    digit_en[0] = 1'b0;
    digit_data[6:0] = 7'h12;
    chk("ds_c3_seg", 32'(seg), 32'h40);
    chk("ds_c3_an", 32'(an), 32'hE);
    step();
    chk("ds_c4_seg", 32'(seg), 32'h12);
    chk("ds_c4_an", 32'(an), 32'hE);
    step();
    chk("ds_c5_seg", 32'(seg), 32'h12);
    chk("ds_c5_an", 32'(an), 32'hE);
    codes[0] = 7'h12;
    while (cyc < 25) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dark0_an", 32'(an), 32'hF);
      chk("dark0_seg", 32'(seg), 32'h7F);
    end
    step();
    chk("after_dark0_cur", 32'(cur_digit), 32'd1);

    // Async reset mid-SHOW at cycle 15
    rst = 1'b1;
    digit_en = 4'hF;
    codes[0] = 7'h40;
    digit_data[6:0] = 7'h40;
    release_rst();
    run_to("pre_rst15", 15, 4'hF);
    chk("c15_an", 32'(an), 32'hB);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst15");
    release_rst();
    run_to("post_rst15", 48, 4'hF);
    chk("stb48", 32'(sample_stb), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst_stb");
    release_rst();
    run_to("post_rst_stb", 8, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
